// File: rtl/buffer_loader.sv
// buffer_loader: streams upstream valid/ready words into the PE memory banks
// through the memory buffer's mode-0 write port (one-hot bank enable, shared
// address, shared data). Fills cfg_len words of each of the first cfg_nbanks
// banks starting at cfg_base, in bank-major or word-interleaved order.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, cfg_*        operation launch and its configuration (sampled in IDLE)
//   s_valid/s_ready/s_data  upstream word stream
//   m0_w_en/addr/data   registered bank write port (one-hot enable)
//   busy, done, err     status: in progress, completion pulse, illegal-config pulse

// Per-bank write-enable register.
module buffer_loader_lane #(
  parameter int NB_W = 4,
  parameter int IDX  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc,
  input  logic [NB_W-1:0] bank,
  output logic            w_en
);
  always_ff @(posedge clk) begin
    if (rst) w_en <= 1'b0;
    else     w_en <= acc && (bank == NB_W'(IDX));
  end
endmodule

module buffer_loader #(
  parameter int N_PE   = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int NB_W   = $clog2(N_PE) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [NB_W-1:0]   cfg_nbanks,
  input  logic              cfg_interleave,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [N_PE-1:0]   m0_w_en,
  output logic [ADDR_W-1:0] m0_w_addr,
  output logic [DATA_W-1:0] m0_w_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, len_q, w_q;
  logic [NB_W-1:0]   nb_q, b_q;
  logic              il_q;

  logic go, cfg_ok, acc, w_last, b_last, last;

  assign go     = start && (state == IDLE);
  assign cfg_ok = (cfg_nbanks != '0) && (cfg_nbanks <= NB_W'(N_PE));
  assign acc    = (state == LOAD) && s_valid;
  assign w_last = (w_q == len_q - ADDR_W'(1));
  assign b_last = (b_q == nb_q - NB_W'(1));
  // Both orderings finish on the (last bank, last word) beat.
  assign last   = acc && w_last && b_last;

  assign s_ready = (state == LOAD);
  assign busy    = (state != IDLE);
  assign done    = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go && cfg_ok) state_nxt = (cfg_len == '0) ? FLUSH : LOAD;
      LOAD:    if (last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      nb_q      <= '0;
      il_q      <= 1'b0;
      w_q       <= '0;
      b_q       <= '0;
      m0_w_addr <= '0;
      m0_w_data <= '0;
      err       <= 1'b0;
    end else begin
      err <= go && !cfg_ok;
      if (go && cfg_ok) begin
        base_q <= cfg_base;
        len_q  <= cfg_len;
        nb_q   <= cfg_nbanks;
        il_q   <= cfg_interleave;
        w_q    <= '0;
        b_q    <= '0;
      end else if (acc) begin
        if (il_q) begin
          if (b_last) begin
            b_q <= '0;
            w_q <= w_q + ADDR_W'(1);
          end else begin
            b_q <= b_q + NB_W'(1);
          end
        end else begin
          if (w_last) begin
            w_q <= '0;
            b_q <= b_q + NB_W'(1);
          end else begin
            w_q <= w_q + ADDR_W'(1);
          end
        end
      end
      // Address/data hold their last value between writes; wrap is modulo 2^ADDR_W.
      if (acc) begin
        m0_w_addr <= base_q + w_q;
        m0_w_data <= s_data;
      end
    end
  end

  for (genvar i = 0; i < N_PE; i++) begin : g_lane
    buffer_loader_lane #(.NB_W(NB_W), .IDX(i)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .acc  (acc),
      .bank (b_q),
      .w_en (m0_w_en[i])
    );
  end

endmodule

// File: tb/tb_buffer_loader.sv
module tb_buffer_loader;
  localparam int N_PE = 8, ADDR_W = 10, DATA_W = 16, NB_W = 4;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0, cfg_len = '0;
  logic [NB_W-1:0]   cfg_nbanks = '0;
  logic              cfg_interleave = 1'b0, s_valid = 1'b0, s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [N_PE-1:0]   m0_w_en;
  logic [ADDR_W-1:0] m0_w_addr;
  logic [DATA_W-1:0] m0_w_data;
  logic              busy, done, err;

  buffer_loader #(.N_PE(N_PE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NB_W(NB_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_nbanks(cfg_nbanks), .cfg_interleave(cfg_interleave), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m0_w_en(m0_w_en), .m0_w_addr(m0_w_addr),
    .m0_w_data(m0_w_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // write/status log, sampled mid-cycle
  int              wq_cyc[$];
  logic [N_PE-1:0] wq_en[$];
  logic [9:0]      wq_ad[$];
  logic [15:0]     wq_da[$];
  int done_cnt = 0, done_cyc = -1, err_cnt = 0;

  always @(negedge clk) begin
    if (m0_w_en != '0) begin
      wq_cyc.push_back(cyc);
      wq_en.push_back(m0_w_en);
      wq_ad.push_back(m0_w_addr);
      wq_da.push_back(m0_w_data);
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (err === 1'b1) err_cnt++;
  end

  // stimulus and expectation tables
  logic [15:0]     sd[8];
  bit              sv[8];
  logic [N_PE-1:0] e_en[6];
  logic [9:0]      e_ad[6];
  logic [15:0]     e_da[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wq_cyc.delete(); wq_en.delete(); wq_ad.delete(); wq_da.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0;
  endtask

  task automatic do_start(input logic [9:0] base, input logic [9:0] len,
                          input logic [3:0] nb, input logic il);
    @(posedge clk); #1;
    start = 1'b1; cfg_base = base; cfg_len = len; cfg_nbanks = nb; cfg_interleave = il;
    @(posedge clk); #1;
    start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_nbanks = '0; cfg_interleave = 1'b0;
  endtask

  // inj >= 0 pulses start with a different config alongside that beat
  task automatic send_beats(input int n, input int inj);
    for (int i = 0; i < n; i++) begin
      s_valid = sv[i]; s_data = sd[i];
      if (i == inj) begin
        start = 1'b1; cfg_base = 10'h200; cfg_len = 10'd1; cfg_nbanks = 4'd1; cfg_interleave = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_nbanks = '0; cfg_interleave = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 20) begin @(posedge clk); #1; k++; end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, wq_cyc.size(), n);
    for (int i = 0; i < n && i < wq_cyc.size(); i++) begin
      chk($sformatf("%s_en%0d", tag, i), {24'd0, wq_en[i]}, {24'd0, e_en[i]});
      chk($sformatf("%s_ad%0d", tag, i), {22'd0, wq_ad[i]}, {22'd0, e_ad[i]});
      chk($sformatf("%s_da%0d", tag, i), {16'd0, wq_da[i]}, {16'd0, e_da[i]});
    end
  endtask

  task automatic bank_major_run(input string tag, input int inj);
    sd = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
    sv = '{1, 1, 1, 1, 1, 1, 0, 0};
    e_en = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};
    e_ad = '{10'h010, 10'h011, 10'h012, 10'h010, 10'h011, 10'h012};
    e_da = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    clear_log();
    do_start(10'h010, 10'd3, 4'd2, 1'b0);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    send_beats(6, inj);
    wait_idle(tag);
    check_writes(tag, 6);
    if (wq_cyc.size() == 6) begin
      chk({tag, "_consec"}, wq_cyc[5] - wq_cyc[0], 32'd5);
      chk({tag, "_donecyc"}, done_cyc, wq_cyc[5]);
    end
    chk({tag, "_ndone"}, done_cnt, 32'd1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_en", {24'd0, m0_w_en}, 32'd0);
    chk("rst_addr", {22'd0, m0_w_addr}, 32'd0);
    chk("rst_data", {16'd0, m0_w_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // bank-major fill
    bank_major_run("bm", -1);

    // interleaved fill
    sd = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'hF, 16'd0, 16'd0};
    sv = '{1, 1, 1, 1, 1, 1, 0, 0};
    e_en = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02, 8'h04};
    e_ad = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd1, 10'd1};
    e_da = '{16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'hF};
    clear_log();
    do_start(10'h000, 10'd2, 4'd3, 1'b1);
    send_beats(6, -1);
    wait_idle("il");
    check_writes("il", 6);
    chk("il_ndone", done_cnt, 32'd1);
    if (wq_cyc.size() == 6) chk("il_donecyc", done_cyc, wq_cyc[5]);

    // backpressure and address wrap
    sd = '{16'h11, 16'hDEAD, 16'h22, 16'h33, 16'hBEEF, 16'h44, 16'd0, 16'd0};
    sv = '{1, 0, 1, 1, 0, 1, 0, 0};
    e_en = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    e_ad = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h000, 10'h000};
    e_da = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h0, 16'h0};
    clear_log();
    do_start(10'h3FE, 10'd4, 4'd1, 1'b0);
    send_beats(6, -1);
    wait_idle("bp");
    check_writes("bp", 4);
    if (wq_cyc.size() == 4) begin
      chk("bp_gap1", wq_cyc[1] - wq_cyc[0], 32'd2);
      chk("bp_gap2", wq_cyc[2] - wq_cyc[1], 32'd1);
      chk("bp_gap3", wq_cyc[3] - wq_cyc[2], 32'd2);
    end
    chk("bp_ndone", done_cnt, 32'd1);

    // len = 0
    clear_log();
    do_start(10'h005, 10'd0, 4'd2, 1'b0);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd1);
    chk("len0_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    chk("len0_busy_after", {31'd0, busy}, 32'd0);
    chk("len0_nwr", wq_cyc.size(), 32'd0);
    chk("len0_ndone", done_cnt, 32'd1);

    // nbanks = 0 and nbanks = N_PE+1
    for (int k = 0; k < 2; k++) begin
      clear_log();
      do_start(10'h005, 10'd2, (k == 0) ? 4'd0 : 4'd9, 1'b0);
      chk($sformatf("nb%0d_err", k), {31'd0, err}, 32'd1);
      chk($sformatf("nb%0d_busy", k), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("nb%0d_err_after", k), {31'd0, err}, 32'd0);
      chk($sformatf("nb%0d_nerr", k), err_cnt, 32'd1);
      chk($sformatf("nb%0d_nwr", k), wq_cyc.size(), 32'd0);
      chk($sformatf("nb%0d_ndone", k), done_cnt, 32'd0);
    end

    // start while busy is ignored
    bank_major_run("sb", 2);

    // reset mid-load, then a fresh full load
    sd = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
    sv = '{1, 1, 1, 1, 1, 1, 0, 0};
    clear_log();
    do_start(10'h010, 10'd3, 4'd2, 1'b0);
    send_beats(2, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_ready", {31'd0, s_ready}, 32'd0);
    chk("mr_en", {24'd0, m0_w_en}, 32'd0);
    chk("mr_addr", {22'd0, m0_w_addr}, 32'd0);
    chk("mr_data", {16'd0, m0_w_data}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_err", {31'd0, err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_nwr", wq_cyc.size(), 32'd2);
    chk("mr_ndone", done_cnt, 32'd0);
    bank_major_run("mr2", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
